// File: rtl/matrix_row_scanner.sv
// Row-multiplexed scanner for a 7-row x 5-column glyph matrix.
// Each row is held for DWELL cycles. The first BLANK cycles of a row period are dark
// so that the row drivers switch cleanly. FRAME is captured into a shadow register
// only at frame start, which keeps the picture from tearing mid-scan.
module matrix_row_scanner #(
   parameter int unsigned DWELL = 1000,
   parameter int unsigned BLANK = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        EN,
   input  logic [34:0] FRAME,
   output logic [6:0]  ROW,
   output logic [4:0]  COL,
   output logic [2:0]  ROW_IDX,
   output logic        FRAME_SYNC
);

   localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] LastCount = CW'(DWELL - 1);

   typedef enum logic [1:0] {StIdle, StBlank, StShow} state_t;

   state_t        r_state;
   logic [CW-1:0] r_count;
   logic [2:0]    r_row_idx;
   logic [34:0]   r_shadow;
   logic [6:0]    r_row;
   logic [4:0]    r_col;
   logic          r_frame_sync;

   state_t        w_state_d;
   logic [CW-1:0] w_count_d;
   logic [2:0]    w_idx_d;
   logic [34:0]   w_shadow_d;
   logic          w_sync_d;
   logic          w_active;
   logic          w_in_blank;
   logic [6:0]    w_row_d;
   logic [4:0]    w_col_d;

   // Dwell counter, row index and shadow advance; frame start reloads the shadow
   always_comb begin
      w_count_d  = r_count;
      w_idx_d    = r_row_idx;
      w_shadow_d = r_shadow;
      w_sync_d   = 1'b0;
      w_active   = 1'b1;
      if (!EN) begin
         w_active  = 1'b0;
         w_count_d = '0;
         w_idx_d   = 3'd0;
      end else if (r_state == StIdle) begin
         w_count_d  = '0;
         w_idx_d    = 3'd0;
         w_shadow_d = FRAME;
         w_sync_d   = 1'b1;
      end else if (r_count == LastCount) begin
         w_count_d = '0;
         if (r_row_idx == 3'd6) begin
            w_idx_d    = 3'd0;
            w_shadow_d = FRAME;
            w_sync_d   = 1'b1;
         end else begin
            w_idx_d = r_row_idx + 3'd1;
         end
      end else begin
         w_count_d = r_count + 1'b1;
      end
   end

   // With no blanking the compare would be against zero, so drop it entirely
   if (BLANK == 0) begin : g_no_blank
      assign w_in_blank = 1'b0;
   end else begin : g_blank
      assign w_in_blank = (w_count_d < CW'(BLANK));
   end

   // Next state and next output values, derived from the advanced counter and index
   always_comb begin
      w_state_d = StShow;
      w_row_d   = 7'd0;
      w_col_d   = 5'd0;
      if (!w_active) begin
         w_state_d = StIdle;
      end else if (w_in_blank) begin
         w_state_d = StBlank;
      end else begin
         w_row_d = 7'b000_0001 << w_idx_d;
         w_col_d = w_shadow_d[5*int'(w_idx_d) +: 5];
      end
   end

   // All state and outputs are flops so ROW can never glitch to two bits
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state      <= StIdle;
         r_count      <= '0;
         r_row_idx    <= 3'd0;
         r_shadow     <= 35'd0;
         r_row        <= 7'd0;
         r_col        <= 5'd0;
         r_frame_sync <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_count      <= w_count_d;
         r_row_idx    <= w_idx_d;
         r_shadow     <= w_shadow_d;
         r_row        <= w_row_d;
         r_col        <= w_col_d;
         r_frame_sync <= w_sync_d;
      end
   end

   assign ROW        = r_row;
   assign COL        = r_col;
   assign ROW_IDX    = r_row_idx;
   assign FRAME_SYNC = r_frame_sync;

endmodule

// File: tb/tb_matrix_row_scanner.sv
// Directed bench for matrix_row_scanner with DWELL=4: one instance with BLANK=1 and
// one with BLANK=0, driven by the same clock, reset, enable and frame.
module tb_matrix_row_scanner;

   logic        CLK;
   logic        RST;
   logic        EN;
   logic [34:0] FRAME;

   logic [6:0]  u0_row;
   logic [4:0]  u0_col;
   logic [2:0]  u0_idx;
   logic        u0_sync;
   logic [6:0]  u1_row;
   logic [4:0]  u1_col;
   logic [2:0]  u1_idx;
   logic        u1_sync;

   int n_total = 0;
   int n_bad   = 0;

   // Rows 0..6: 10101 01010 11100 00111 10001 01110 11011
   localparam logic [34:0] FrameA =
      {5'b11011, 5'b01110, 5'b10001, 5'b00111, 5'b11100, 5'b01010, 5'b10101};

   matrix_row_scanner #(.DWELL(4), .BLANK(1)) u_dut0 (
      .CLK        (CLK),
      .RST        (RST),
      .EN         (EN),
      .FRAME      (FRAME),
      .ROW        (u0_row),
      .COL        (u0_col),
      .ROW_IDX    (u0_idx),
      .FRAME_SYNC (u0_sync)
   );

   matrix_row_scanner #(.DWELL(4), .BLANK(0)) u_dut1 (
      .CLK        (CLK),
      .RST        (RST),
      .EN         (EN),
      .FRAME      (FRAME),
      .ROW        (u1_row),
      .COL        (u1_col),
      .ROW_IDX    (u1_idx),
      .FRAME_SYNC (u1_sync)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [34:0] got, input logic [34:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, " u0 row"},  35'(u0_row),  35'd0);
      check_eq({tag, " u0 col"},  35'(u0_col),  35'd0);
      check_eq({tag, " u0 idx"},  35'(u0_idx),  35'd0);
      check_eq({tag, " u0 sync"}, 35'(u0_sync), 35'd0);
      check_eq({tag, " u1 row"},  35'(u1_row),  35'd0);
      check_eq({tag, " u1 col"},  35'(u1_col),  35'd0);
      check_eq({tag, " u1 idx"},  35'(u1_idx),  35'd0);
      check_eq({tag, " u1 sync"}, 35'(u1_sync), 35'd0);
   endtask

   // Expected outputs k cycles after a frame-start sync, with fr as the latched frame
   task automatic check_cycle(input int k, input logic [34:0] fr);
      int r;
      int c;
      logic [6:0] onehot;
      logic [4:0] pix;
      r      = (k % 28) / 4;
      c      = k % 4;
      onehot = 7'd1 << r;
      pix    = fr[5*r +: 5];
      check_eq($sformatf("u0 sync k=%0d", k), 35'(u0_sync), 35'((k % 28) == 0));
      check_eq($sformatf("u0 idx k=%0d", k),  35'(u0_idx),  35'(r));
      check_eq($sformatf("u0 row k=%0d", k),  35'(u0_row),  35'((c == 0) ? 7'd0 : onehot));
      check_eq($sformatf("u0 col k=%0d", k),  35'(u0_col),  35'((c == 0) ? 5'd0 : pix));
      check_eq($sformatf("u1 sync k=%0d", k), 35'(u1_sync), 35'((k % 28) == 0));
      check_eq($sformatf("u1 idx k=%0d", k),  35'(u1_idx),  35'(r));
      check_eq($sformatf("u1 row k=%0d", k),  35'(u1_row),  35'(onehot));
      check_eq($sformatf("u1 col k=%0d", k),  35'(u1_col),  35'(pix));
   endtask

   initial begin
      RST   = 1'b1;
      EN    = 1'b0;
      FRAME = 35'd0;
      #1;
      check_idle("reset");
      step();
      step();
      check_idle("reset held");

      // Release reset between edges with EN high: the next edge is frame cycle 0
      FRAME = FrameA;
      EN    = 1'b1;
      #3;
      RST = 1'b0;

      // Two and a half frames; frame 1 must show the all-zero FRAME set mid frame 0
      for (int k = 0; k <= 69; k++) begin
         step();
         check_cycle(k, ((k / 28) == 1) ? 35'd0 : FrameA);
         if (k == 10) FRAME = 35'd0;
         if (k == 40) FRAME = FrameA;
      end

      // k=69 is row 3 shown; drop enable
      EN = 1'b0;
      step();
      check_idle("en drop");
      step();
      check_idle("idle hold");

      EN = 1'b1;
      for (int k = 0; k <= 21; k++) begin
         step();
         check_cycle(k, FrameA);
      end

      // k=21 is row 5 shown; assert reset mid-cycle, outputs must clear before next edge
      #2;
      RST = 1'b1;
      #1;
      check_idle("async rst");
      step();
      check_idle("rst hold");

      #3;
      RST = 1'b0;
      step();
      check_cycle(0, FrameA);
      step();
      check_cycle(1, FrameA);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/matrix_row_scanner.md
MATRIX_ROW_SCANNER -- requirements
Module: matrix_row_scanner

Interface
REQ-001 Parameters SHALL be: DWELL, default 1000, clock cycles per row period; BLANK, default 8, blanked cycles at the start of each row period.
REQ-002 Parameter legality SHALL be: DWELL >= 2 and 0 <= BLANK < DWELL; the dwell counter width SHALL be clog2(DWELL).
REQ-003 CLK  input  1  single clock; all flops rising-edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 EN  input  1  scan enable; level-sensitive.
REQ-006 FRAME  input  35  pixel frame for a 7-row x 5-column glyph matrix; bit 5*r+c = pixel row r (0..6), column c (0..4); 1 = lit; same ordering as the glyph multiplexer outputs OUTrc.
REQ-007 ROW  output  7  row drive, one-hot active-high; bit r = row r energised.
REQ-008 COL  output  5  column data for the energised row, active-high; bit c = column c.
REQ-009 ROW_IDX  output  3  index of the current row period, 0..6.
REQ-010 FRAME_SYNC  output  1  one-cycle pulse on the first cycle of each frame.
REQ-011 Clocking SHALL be one clock; reset SHALL be asynchronous and active-high.

Function
REQ-012 States SHALL be IDLE, BLANK and SHOW; ROW, COL, ROW_IDX and FRAME_SYNC SHALL be driven directly from flops.
REQ-013 In IDLE, ROW=0, COL=0, ROW_IDX=0 and FRAME_SYNC=0.
REQ-014 IDLE with EN=1 SHALL, on the next cycle, set ROW_IDX=0 and count=0, latch FRAME into a 35-bit shadow register, and assert FRAME_SYNC for that cycle.
REQ-015 Each row period SHALL last exactly DWELL cycles (count 0..DWELL-1).
REQ-016 For count < BLANK (BLANK state), ROW=0 and COL=0.
REQ-017 For count >= BLANK (SHOW state), ROW has only bit ROW_IDX set and COL = shadow[5*ROW_IDX+4 : 5*ROW_IDX].
REQ-018 After count=DWELL-1, ROW_IDX SHALL increment; ROW_IDX 6 SHALL wrap to 0.
REQ-019 On that wrap, the shadow SHALL be reloaded from FRAME and FRAME_SYNC SHALL pulse; the frame period SHALL be 7*DWELL cycles.
REQ-020 FRAME SHALL be sampled only at frame start, so changes mid-frame cannot tear the display.
REQ-021 With BLANK=0, the BLANK state SHALL never be entered and rows SHALL abut with no zero gap.
REQ-022 ROW SHALL never have more than one bit set in any cycle, including at row transitions.
REQ-023 EN=0 in any state SHALL, on the next cycle, force IDLE, ROW=0, COL=0, ROW_IDX=0 and count=0; re-enabling SHALL restart per REQ-014.
REQ-024 The shadow SHALL hold its value in IDLE; it is not cleared.

Reset
REQ-025 RST=1 SHALL immediately (asynchronously) force IDLE, ROW=0, COL=0, ROW_IDX=0, FRAME_SYNC=0, count=0 and shadow=0.
REQ-026 After RST deasserts with EN=1, the first FRAME_SYNC SHALL occur on the first rising CLK edge with RST low.
REQ-027 Reset mid-row SHALL cut the row drive without waiting for the row period to end.

Verification (DWELL=4, BLANK=1 unless stated)
REQ-028 Assert RST mid-cycle while row 5 is shown -> ROW=0, COL=0, ROW_IDX=0 and FRAME_SYNC=0 before the next CLK edge.
REQ-029 FRAME[4:0]=5'b10101, FRAME[9:5]=5'b01010, EN rises -> cycle 0: FRAME_SYNC=1, ROW=0; cycles 1-3: ROW=7'b0000001, COL=5'b10101; cycle 4: ROW=0; cycles 5-7: ROW=7'b0000010, COL=5'b01010.
REQ-030 Change FRAME to all-zeros at cycle 10 -> rows 2..6 still show the old shadow; next FRAME_SYNC at cycle 28, after which all COL=0.
REQ-031 Drop EN during row 3 SHOW -> next cycle ROW=0, COL=0, ROW_IDX=0; raise EN -> FRAME_SYNC pulse and the scan restarts at row 0.
REQ-032 FRAME all ones, BLANK=0 build -> ROW walks 0000001..1000000 with 4 cycles each, COL=5'b11111 every cycle, no cycle with ROW=0, never two ROW bits set.
REQ-033 Free-run for 3 frames -> FRAME_SYNC pulses exactly at cycles 0, 28 and 56, each exactly one cycle wide.
